// File: rtl/riscv_core_mul_div_ctrl.sv
// Issue/sequencing controller for the M-extension unit: latches one MUL/DIV op, stalls EX until the result
// is captured, pulses writeback, handles flush and a divide watchdog. Optional DIV result cache: MUL_DIV_DIV_CACHE_EN.
module riscv_core_mul_div_ctrl #(
   parameter int XLEN        = 64,
   parameter int DIV_TIMEOUT = XLEN + 8
) (
   input  logic            i_mdc_clk,
   input  logic            i_mdc_rstn,
   input  logic            i_mdc_valid,
   input  logic [3:0]      i_mdc_control,
   input  logic            i_mdc_isword,
   input  logic [XLEN-1:0] i_mdc_srcA,
   input  logic [XLEN-1:0] i_mdc_srcB,
   input  logic [4:0]      i_mdc_rd,
   input  logic            i_mdc_flush,
   output logic            o_mdc_unit_en,
   output logic [XLEN-1:0] o_mdc_unit_srcA,
   output logic [XLEN-1:0] o_mdc_unit_srcB,
   output logic [3:0]      o_mdc_unit_control,
   output logic            o_mdc_unit_isword,
   input  logic            i_mdc_unit_done,
   input  logic [XLEN-1:0] i_mdc_unit_result,
   output logic            o_mdc_stall,
   output logic            o_mdc_wb_valid,
   output logic [4:0]      o_mdc_wb_rd,
   output logic [XLEN-1:0] o_mdc_wb_result,
   output logic            o_mdc_err,
   output logic [1:0]      o_mdc_dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   localparam int            CW     = $clog2(DIV_TIMEOUT + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DIV_TIMEOUT - 1);

   // Handshake: an op is taken in IDLE when i_mdc_valid is high and i_mdc_flush is low; o_mdc_stall is the
   // not-ready back-pressure and o_mdc_wb_valid is a single-cycle result strobe with no ready.
   logic [1:0]      r_state;
   logic [XLEN-1:0] r_srcA;
   logic [XLEN-1:0] r_srcB;
   logic [3:0]      r_control;
   logic            r_isword;
   logic [4:0]      r_rd;
   logic [CW-1:0]   r_cnt;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_result;

   logic            w_issue;
   logic            w_div_done;
   logic            w_div_timeout;
   logic            w_c_hit;
   logic            w_skip;
   logic [XLEN-1:0] w_mul_result;

   assign w_issue       = (r_state == S_IDLE) & i_mdc_valid & ~i_mdc_flush;
   assign w_div_done    = (r_state == S_DIV) & ~i_mdc_flush & i_mdc_unit_done;
   assign w_div_timeout = (r_state == S_DIV) & ~i_mdc_flush & ~i_mdc_unit_done & (r_cnt == C_LAST);

`ifdef MUL_DIV_DIV_CACHE_EN
   logic            r_c_valid;
   logic [XLEN-1:0] r_c_srcA;
   logic [XLEN-1:0] r_c_srcB;
   logic [XLEN-1:0] r_c_result;
   logic [3:0]      r_c_control;
   logic            r_c_isword;
   logic            r_hit;

   assign w_c_hit = r_c_valid & i_mdc_control[2] &
                    (i_mdc_srcA == r_c_srcA) & (i_mdc_srcB == r_c_srcB) &
                    (i_mdc_control == r_c_control) & (i_mdc_isword == r_c_isword);
   assign w_skip       = r_hit;
   assign w_mul_result = r_hit ? r_c_result : i_mdc_unit_result;

   // A cache hit rides the MUL state with the unit idle; only divider completions refill the entry.
   always_ff @(posedge i_mdc_clk) begin
      if (!i_mdc_rstn) begin
         r_c_valid   <= 1'b0;
         r_c_srcA    <= '0;
         r_c_srcB    <= '0;
         r_c_result  <= '0;
         r_c_control <= '0;
         r_c_isword  <= 1'b0;
         r_hit       <= 1'b0;
      end else begin
         if (w_issue) begin
            r_hit <= w_c_hit;
         end
         if (w_div_timeout) begin
            r_c_valid <= 1'b0;
         end else if (w_div_done) begin
            r_c_valid   <= 1'b1;
            r_c_srcA    <= r_srcA;
            r_c_srcB    <= r_srcB;
            r_c_control <= r_control;
            r_c_isword  <= r_isword;
            r_c_result  <= i_mdc_unit_result;
         end
      end
   end
`else
   assign w_c_hit      = 1'b0;
   assign w_skip       = 1'b0;
   assign w_mul_result = i_mdc_unit_result;
`endif

   always_ff @(posedge i_mdc_clk) begin
      if (!i_mdc_rstn) begin
         r_state     <= S_IDLE;
         r_srcA      <= '0;
         r_srcB      <= '0;
         r_control   <= '0;
         r_isword    <= 1'b0;
         r_rd        <= '0;
         r_cnt       <= '0;
         r_wb_rd     <= '0;
         r_wb_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_srcA    <= i_mdc_srcA;
                  r_srcB    <= i_mdc_srcB;
                  r_control <= i_mdc_control;
                  r_isword  <= i_mdc_isword;
                  r_rd      <= i_mdc_rd;
                  r_cnt     <= '0;
                  r_state   <= (i_mdc_control[2] & ~w_c_hit) ? S_DIV : S_MUL;
               end
            end
            S_MUL: begin
               if (i_mdc_flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wb_rd     <= r_rd;
                  r_wb_result <= w_mul_result;
                  r_state     <= S_WB;
               end
            end
            S_DIV: begin
               // Flush beats completion, and completion beats the watchdog in the same cycle.
               if (i_mdc_flush) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else if (i_mdc_unit_done) begin
                  r_cnt       <= '0;
                  r_wb_rd     <= r_rd;
                  r_wb_result <= i_mdc_unit_result;
                  r_state     <= S_WB;
               end else if (r_cnt == C_LAST) begin
                  r_cnt       <= '0;
                  r_wb_rd     <= r_rd;
                  r_wb_result <= {XLEN{1'b1}};
                  r_state     <= S_WB;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WB: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_mdc_unit_en      = ((r_state == S_MUL) & ~w_skip) | (r_state == S_DIV);
   assign o_mdc_unit_srcA    = r_srcA;
   assign o_mdc_unit_srcB    = r_srcB;
   assign o_mdc_unit_control = r_control;
   assign o_mdc_unit_isword  = r_isword;
   assign o_mdc_stall        = ((r_state == S_IDLE) & i_mdc_valid) | (r_state == S_MUL) | (r_state == S_DIV);
   assign o_mdc_wb_valid     = (r_state == S_WB) & ~i_mdc_flush;
   assign o_mdc_wb_rd        = r_wb_rd;
   assign o_mdc_wb_result    = r_wb_result;
   assign o_mdc_err          = w_div_timeout;
   assign o_mdc_dbg_state    = r_state;

endmodule

// File: tb/tb_riscv_core_mul_div_ctrl.sv
// Randomized bench for riscv_core_mul_div_ctrl: transaction-level model of op latency, flush, watchdog and
// (when MUL_DIV_DIV_CACHE_EN is defined) the DIV result cache, with a behavioural mul/div unit.
module tb_riscv_core_mul_div_ctrl;

   localparam int XLEN = 64;
   localparam int TO   = XLEN + 8;

   logic            clk = 1'b0;
   logic            rstn;
   logic            valid;
   logic [3:0]      control;
   logic            isword;
   logic [XLEN-1:0] srcA;
   logic [XLEN-1:0] srcB;
   logic [4:0]      rd;
   logic            flush;
   logic            unit_done;
   logic [XLEN-1:0] unit_result;
   logic            o_unit_en;
   logic [XLEN-1:0] o_unit_srcA;
   logic [XLEN-1:0] o_unit_srcB;
   logic [3:0]      o_unit_control;
   logic            o_unit_isword;
   logic            o_stall;
   logic            o_wb_valid;
   logic [4:0]      o_wb_rd;
   logic [XLEN-1:0] o_wb_result;
   logic            o_err;
   logic [1:0]      o_dbg_state;

   int              n_tests = 0;
   int              n_fail  = 0;
   logic [XLEN-1:0] exp_q[$];

   // Reference cache contents: last DIV that finished through the divider.
   bit              c_valid = 1'b0;
   logic [XLEN-1:0] c_a, c_b;
   logic [3:0]      c_c;
   logic            c_w;

   riscv_core_mul_div_ctrl #(.XLEN(XLEN), .DIV_TIMEOUT(TO)) dut (
      .i_mdc_clk          (clk),
      .i_mdc_rstn         (rstn),
      .i_mdc_valid        (valid),
      .i_mdc_control      (control),
      .i_mdc_isword       (isword),
      .i_mdc_srcA         (srcA),
      .i_mdc_srcB         (srcB),
      .i_mdc_rd           (rd),
      .i_mdc_flush        (flush),
      .o_mdc_unit_en      (o_unit_en),
      .o_mdc_unit_srcA    (o_unit_srcA),
      .o_mdc_unit_srcB    (o_unit_srcB),
      .o_mdc_unit_control (o_unit_control),
      .o_mdc_unit_isword  (o_unit_isword),
      .i_mdc_unit_done    (unit_done),
      .i_mdc_unit_result  (unit_result),
      .o_mdc_stall        (o_stall),
      .o_mdc_wb_valid     (o_wb_valid),
      .o_mdc_wb_rd        (o_wb_rd),
      .o_mdc_wb_result    (o_wb_result),
      .o_mdc_err          (o_err),
      .o_mdc_dbg_state    (o_dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] unit_model(input logic [3:0] c, input logic w,
                                                  input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      if (!c[2]) r = a * b;
      else       r = (b == 0) ? '1 : a / b;
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   // The divider's result bus carries garbage until it reports done.
   assign unit_result = (o_unit_control[2] && !unit_done) ? 64'h0BAD_F00D_0BAD_F00D :
                        unit_model(o_unit_control, o_unit_isword, o_unit_srcA, o_unit_srcB);

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one op from its issue cycle to the cycle after WB (or to the IDLE cycle after an abort).
   task automatic run_op(input logic [3:0] c, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] r, input int done_at, input int flush_at,
                         input bit wb_flush, input bit valid_in_wb);
      bit              is_div, hit, timeout, flushed;
      int              last;
      logic [XLEN-1:0] res;
      is_div = c[2];
      hit    = 1'b0;
`ifdef MUL_DIV_DIV_CACHE_EN
      hit = is_div && c_valid && (c_a == a) && (c_b == b) && (c_c == c) && (c_w == w);
`endif
      res     = unit_model(c, w, a, b);
      timeout = 1'b0;
      if (!is_div || hit) last = 1;
      else if (done_at >= 1 && done_at <= TO) last = done_at;
      else begin
         last    = TO;
         timeout = 1'b1;
         res     = '1;
      end
      flushed = (flush_at >= 1) && (flush_at <= last);
      if (flushed) last = flush_at;
      else exp_q.push_back(res);

      valid = 1'b1; control = c; isword = w; srcA = a; srcB = b; rd = r;
      @(negedge clk);
      check("issue_stall", o_stall, 1);
      check("issue_unit_en", o_unit_en, 0);
      check("issue_wb_valid", o_wb_valid, 0);
      step();
      valid = 1'b0; srcA = {$urandom, $urandom}; srcB = {$urandom, $urandom};
      control = 4'($urandom_range(0, 15)); isword = 1'($urandom_range(0, 1)); rd = 5'($urandom_range(0, 31));

      for (int k = 1; k <= last; k++) begin
         unit_done = is_div && !hit && (k == done_at);
         flush     = (k == flush_at);
         @(negedge clk);
         check("busy_stall", o_stall, 1);
         check("busy_unit_en", o_unit_en, !hit);
         check("busy_err", o_err, timeout && !flushed && (k == last));
         check("busy_wb_valid", o_wb_valid, 0);
         check("unit_srcA", o_unit_srcA, a);
         check("unit_srcB", o_unit_srcB, b);
         check("unit_control", o_unit_control, c);
         check("unit_isword", o_unit_isword, w);
         step();
      end
      unit_done = 1'b0;
      flush     = 1'b0;
      if (flushed) return;

      flush = wb_flush;
      if (valid_in_wb) begin
         valid = 1'b1; control = 4'b0000; srcA = 64'd2; srcB = 64'd3;
      end
      @(negedge clk);
      check("wb_valid", o_wb_valid, !wb_flush);
      check("wb_stall", o_stall, 0);
      check("wb_unit_en", o_unit_en, 0);
      check("wb_err", o_err, 0);
      check("wb_rd", o_wb_rd, r);
      if (exp_q.size() > 0) check("wb_result", o_wb_result, exp_q.pop_front());
      else check("wb_queue_empty", 1, 0);
      step();
      flush = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      check("post_wb_valid", o_wb_valid, 0);
      check("post_unit_en", o_unit_en, 0);
      check("hold_rd", o_wb_rd, r);
      check("hold_result", o_wb_result, res);
      step();

      if (timeout) c_valid = 1'b0;
      else if (is_div && !hit) begin
         c_valid = 1'b1; c_a = a; c_b = b; c_c = c; c_w = w;
      end
   endtask

   task automatic reset_mid_div();
      valid = 1'b1; control = 4'b0100; isword = 1'b0; srcA = 64'd100; srcB = 64'd9; rd = 5'd6;
      step();
      valid = 1'b0;
      repeat (3) step();
      rstn = 1'b0;
      step();
      @(negedge clk);
      check("rst_unit_en", o_unit_en, 0);
      check("rst_stall", o_stall, 0);
      check("rst_wb_valid", o_wb_valid, 0);
      check("rst_wb_rd", o_wb_rd, 0);
      check("rst_wb_result", o_wb_result, 0);
      check("rst_unit_srcA", o_unit_srcA, 0);
      check("rst_err", o_err, 0);
      rstn = 1'b1;
      step();
      @(negedge clk);
      check("rst_no_late_wb", o_wb_valid, 0);
      step();
      c_valid = 1'b0;
   endtask

   initial begin
      logic [3:0]      c;
      logic            w;
      logic [XLEN-1:0] a, b;
      rstn = 1'b0; valid = 1'b0; control = '0; isword = 1'b0; srcA = '0; srcB = '0;
      rd = '0; flush = 1'b0; unit_done = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("reset_stall", o_stall, 0);
      check("reset_unit_en", o_unit_en, 0);
      check("reset_wb_valid", o_wb_valid, 0);
      check("reset_wb_rd", o_wb_rd, 0);
      check("reset_wb_result", o_wb_result, 0);
      check("reset_err", o_err, 0);
      check("reset_unit_srcB", o_unit_srcB, 0);
      step();
      rstn = 1'b1;
      step();

      run_op(4'b0000, 1'b0, 64'd3, 64'd5, 5'd7, 0, 0, 1'b0, 1'b0);
      run_op(4'b0100, 1'b0, 64'd100, 64'd7, 5'd9, 10, 0, 1'b0, 1'b0);
      run_op(4'b0100, 1'b0, 64'd200, 64'd3, 5'd4, 6, 4, 1'b0, 1'b0);
      run_op(4'b0000, 1'b0, 64'd6, 64'd7, 5'd2, 0, 0, 1'b0, 1'b0);
      run_op(4'b0100, 1'b0, 64'd55, 64'd5, 5'd3, 0, 0, 1'b0, 1'b0);
      run_op(4'b0100, 1'b0, 64'd100, 64'd7, 5'd1, 5, 0, 1'b0, 1'b0);
      run_op(4'b0100, 1'b0, 64'd100, 64'd7, 5'd1, 5, 0, 1'b0, 1'b0);
      run_op(4'b0100, 1'b0, 64'd100, 64'd9, 5'd8, 4, 0, 1'b0, 1'b1);
      run_op(4'b0001, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'd3, 5'd31, 0, 0, 1'b1, 1'b0);

      valid = 1'b1; flush = 1'b1; control = 4'b0000; srcA = 64'd4; srcB = 64'd4;
      @(negedge clk);
      check("idle_flush_stall", o_stall, 1);
      step();
      valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_flush_no_issue", o_unit_en, 0);
      step();

      reset_mid_div();
      run_op(4'b0100, 1'b0, 64'd100, 64'd9, 5'd6, 3, 0, 1'b0, 1'b0);

      c = 4'b0100; w = 1'b0; a = 64'd1; b = 64'd1;
      repeat (60) begin
         if ($urandom_range(0, 2) != 0) begin
            c = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
            b = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 50));
         end
         run_op(c, w, a, b, 5'($urandom_range(0, 31)),
                ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0,
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0) step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
